calendar_sequencer: RTL and testbench
=====================================

CALENDAR_SEQUENCER -- requirements
Module: calendar_sequencer

Interface
REQ-001 Parameter YEAR_MAX, default 99, is the highest year value; year counts 0..YEAR_MAX.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  load request; when high, load_day/load_month/load_year are sampled this cycle.
REQ-005 load_day  input  5  day to load, 1..31.
REQ-006 load_month  input  4  month to load, 1..12.
REQ-007 load_year  input  7  year to load, 0..YEAR_MAX.
REQ-008 tick  input  1  advance-one-day strobe, one cycle wide.
REQ-009 day  output  5  current day.
REQ-010 month  output  4  current month.
REQ-011 year  output  7  current year.
REQ-012 month_type  output  2  registered class of current month: 00 = 30-day, 01 = 31-day, 10 = February, 11 never driven.
REQ-013 valid  output  1  high while the held date is legal and advancing.
REQ-014 error  output  1  high after a rejected load, until the next accepted load or reset.
REQ-015 month_end  output  1  one-cycle pulse when a tick rolls the day to 1.
REQ-016 year_end  output  1  one-cycle pulse when a tick rolls 31 Dec to 1 Jan.

Function
REQ-017 FSM states: IDLE (no date), RUN (valid date), ERR (bad load); valid=1 only in RUN; error=1 only in ERR.
REQ-018 Transitions: any state + legal load -> RUN; any state + illegal load -> ERR; otherwise stay.
REQ-019 Load is legal iff 1 <= load_month <= 12, 1 <= load_day <= days_in(load_month, load_year), and load_year <= YEAR_MAX.
REQ-020 days_in: months 4/6/9/11 -> 30; February -> 28 (see REQ-031); all other months -> 31.
REQ-021 month_type SHALL be 00 for months 4/6/9/11, 10 for February, and 01 otherwise; it updates in the same edge as month.
REQ-022 On an accepted load, day/month/year take the loaded values at the next edge.
REQ-023 On an illegal load, day/month/year SHALL hold their previous values.
REQ-024 A tick in RUN advances the date by one day, visible on the edge following the tick cycle (latency 1).
REQ-025 If day < days_in, day increments; otherwise day=1 and month_end pulses.
REQ-026 At month rollover: if month < 12, month increments; otherwise month=1, year increments, and year_end pulses alongside month_end.
REQ-027 Year YEAR_MAX rolls to 0 on a year rollover, with no error.
REQ-028 A tick in IDLE or ERR is ignored: no date change, no pulses.
REQ-029 When load and tick are both high in the same cycle, load wins and the tick is discarded.
REQ-030 Back-to-back ticks in consecutive cycles each advance the date by one day; no tick is dropped.

Configuration
REQ-031 With LEAP_YEAR_EN defined, February has 29 days when year[1:0]==2'b00, for both load validation and advancing; without it, February always has 28 days and day 29 in February is rejected on load.

Reset
REQ-032 While rst is high at an edge, the block SHALL enter IDLE and set day=1, month=1, year=0, month_type=01, valid=0, error=0, month_end=0, year_end=0.
REQ-033 rst overrides simultaneous load and tick; a reset during RUN discards the held date.

Verification
REQ-034 Reset, then tick x3 -> date stays 1/1/0, valid=0, no pulses.
REQ-035 Load 30/4/5, then tick -> day=1, month=5, month_type=01, month_end pulses for exactly one cycle.
REQ-036 Load 31/12/99, then tick -> 1/1/0, month_end=1 and year_end=1 in the same cycle.
REQ-037 Load 31/6/3 -> error=1, valid=0, date unchanged; then load 15/6/3 -> RUN, error=0.
REQ-038 Load 28/2/4, then tick -> with LEAP_YEAR_EN, 29/2/4; then another tick -> 1/3/4. Without LEAP_YEAR_EN, the first tick gives 1/3/4, and loading 29/2/4 gives error=1.
REQ-039 Load 10/1/0 with load and tick high together -> date is 10/1/0 (tick discarded); then 20 consecutive ticks -> 30/1/0.

Source files
------------

// File: rtl/calendar_sequencer.sv
// ============================================================================
// Module      : calendar_sequencer
// Description : Day/month/year calendar with load validation and tick advance.
//               Optional macro LEAP_YEAR_EN enables 29-day February when
//               year[1:0] == 2'b00.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calendar_sequencer #(
   parameter int YEAR_MAX = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [4:0] load_day,
   input  logic [3:0] load_month,
   input  logic [6:0] load_year,
   input  logic       tick,
   output logic [4:0] day,
   output logic [3:0] month,
   output logic [6:0] year,
   output logic [1:0] month_type,
   output logic       valid,
   output logic       error,
   output logic       month_end,
   output logic       year_end
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_ERR      = 2'd2;
   localparam logic [6:0] C_YEAR_MAX = 7'(YEAR_MAX);

   logic [1:0] r_state;
   logic [4:0] r_day;
   logic [3:0] r_month;
   logic [6:0] r_year;
   logic [1:0] r_month_type;
   logic       r_month_end;
   logic       r_year_end;

   logic       w_ld_leap;
   logic       w_cur_leap;
   logic       w_ld_legal;
   logic [4:0] w_ld_dim;
   logic [4:0] w_cur_dim;
   logic [3:0] w_next_month;

   function automatic logic [4:0] f_days_in(input logic [3:0] m, input logic leap);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: f_days_in = 5'd30;
         4'd2:                    f_days_in = leap ? 5'd29 : 5'd28;
         default:                 f_days_in = 5'd31;
      endcase
   endfunction

   // 00 = 30-day, 01 = 31-day, 10 = February
   function automatic logic [1:0] f_month_type(input logic [3:0] m);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: f_month_type = 2'b00;
         4'd2:                    f_month_type = 2'b10;
         default:                 f_month_type = 2'b01;
      endcase
   endfunction

`ifdef LEAP_YEAR_EN
   assign w_ld_leap  = (load_year[1:0] == 2'b00);
   assign w_cur_leap = (r_year[1:0] == 2'b00);
`else
   assign w_ld_leap  = 1'b0;
   assign w_cur_leap = 1'b0;
`endif

   assign w_ld_dim     = f_days_in(load_month, w_ld_leap);
   assign w_cur_dim    = f_days_in(r_month, w_cur_leap);
   assign w_next_month = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;

   assign w_ld_legal = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_day >= 5'd1) && (load_day <= w_ld_dim) &&
                       (load_year <= C_YEAR_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_day        <= 5'd1;
         r_month      <= 4'd1;
         r_year       <= 7'd0;
         r_month_type <= 2'b01;
         r_month_end  <= 1'b0;
         r_year_end   <= 1'b0;
      end else begin
         r_month_end <= 1'b0;
         r_year_end  <= 1'b0;
         // A load always takes priority; any concurrent tick is dropped.
         if (load) begin
            if (w_ld_legal) begin
               r_state      <= S_RUN;
               r_day        <= load_day;
               r_month      <= load_month;
               r_year       <= load_year;
               r_month_type <= f_month_type(load_month);
            end else begin
               r_state <= S_ERR;
            end
         end else if (tick && (r_state == S_RUN)) begin
            if (r_day < w_cur_dim) begin
               r_day <= r_day + 5'd1;
            end else begin
               r_day        <= 5'd1;
               r_month_end  <= 1'b1;
               r_month      <= w_next_month;
               r_month_type <= f_month_type(w_next_month);
               if (r_month == 4'd12) begin
                  r_year_end <= 1'b1;
                  r_year     <= (r_year == C_YEAR_MAX) ? 7'd0 : r_year + 7'd1;
               end
            end
         end
      end
   end

   assign day        = r_day;
   assign month      = r_month;
   assign year       = r_year;
   assign month_type = r_month_type;
   assign valid      = (r_state == S_RUN);
   assign error      = (r_state == S_ERR);
   assign month_end  = r_month_end;
   assign year_end   = r_year_end;

endmodule

`default_nettype wire

// File: tb/tb_calendar_sequencer.sv
// ============================================================================
// Module      : tb_calendar_sequencer
// Description : Scoreboard bench for calendar_sequencer with ordinal-day model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calendar_sequencer;

   localparam int YEAR_MAX = 99;
`ifdef LEAP_YEAR_EN
   localparam bit LEAP = 1'b1;
`else
   localparam bit LEAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [4:0] load_day = 5'd1;
   logic [3:0] load_month = 4'd1;
   logic [6:0] load_year = 7'd0;
   logic       tick = 1'b0;
   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;
   logic [1:0] month_type;
   logic       valid;
   logic       error;
   logic       month_end;
   logic       year_end;

   always #5 clk = ~clk;

   calendar_sequencer #(.YEAR_MAX(YEAR_MAX)) u_dut (
      .clk(clk), .rst(rst), .load(load), .load_day(load_day),
      .load_month(load_month), .load_year(load_year), .tick(tick),
      .day(day), .month(month), .year(year), .month_type(month_type),
      .valid(valid), .error(error), .month_end(month_end), .year_end(year_end)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [21:0] exp_q[$];

   // Reference model: date, mode (0 idle, 1 run, 2 err) and pulses
   int m_day = 1, m_month = 1, m_year = 0, m_mode = 0;
   bit m_me = 1'b0, m_ye = 1'b0;

   function automatic int dim(input int m, input int y);
      if (m == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [21:0] pack_exp();
      logic [1:0] mt;
      if (m_month == 2) mt = 2'b10;
      else if (dim(m_month, 0) == 30) mt = 2'b00;
      else mt = 2'b01;
      return {5'(m_day), 4'(m_month), 7'(m_year), mt,
              (m_mode == 1), (m_mode == 2), m_me, m_ye};
   endfunction

   // Advance by converting to day-of-year, incrementing, and converting back.
   task automatic model_advance();
      int doy, ylen, mm;
      doy = m_day;
      for (int k = 1; k < m_month; k++) doy += dim(k, m_year);
      doy++;
      ylen = 0;
      for (int k = 1; k <= 12; k++) ylen += dim(k, m_year);
      if (doy > ylen) begin
         doy    = 1;
         m_year = (m_year + 1) % (YEAR_MAX + 1);
      end
      mm = 1;
      while (doy > dim(mm, m_year)) begin
         doy -= dim(mm, m_year);
         mm++;
      end
      m_day   = doy;
      m_month = mm;
      m_me    = (m_day == 1);
      m_ye    = (m_day == 1) && (m_month == 1);
   endtask

   task automatic step(input bit r, input bit ld, input int d, input int m,
                       input int y, input bit t);
      @(negedge clk);
      rst        = r;
      load       = ld;
      load_day   = 5'(d);
      load_month = 4'(m);
      load_year  = 7'(y);
      tick       = t;
      m_me = 1'b0;
      m_ye = 1'b0;
      if (r) begin
         m_mode = 0; m_day = 1; m_month = 1; m_year = 0;
      end else if (ld) begin
         if (m >= 1 && m <= 12 && d >= 1 && d <= dim(m, y) && y <= YEAR_MAX) begin
            m_mode = 1; m_day = d; m_month = m; m_year = y;
         end else begin
            m_mode = 2;
         end
      end else if (t && m_mode == 1) begin
         model_advance();
      end
      exp_q.push_back(pack_exp());
   endtask

   // Monitor: one expected snapshot per clock after each applied stimulus
   initial begin
      logic [21:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {day, month, year, month_type, valid, error, month_end, year_end};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL state @%0t: got d=%0d m=%0d y=%0d mt=%b v=%b e=%b me=%b ye=%b, want d=%0d m=%0d y=%0d mt=%b v=%b e=%b me=%b ye=%b",
                        $time, a[21:17], a[16:13], a[12:6], a[5:4], a[3], a[2], a[1], a[0],
                        e[21:17], e[16:13], e[12:6], e[5:4], e[3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      int d, m, y;
      bit r, ld, t;
      // Reset then ignored ticks
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 15, 6, 3, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      // 30-day month rollover with single-cycle month_end
      step(0, 1, 30, 4, 5, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      // Year rollover at YEAR_MAX
      step(0, 1, 31, 12, 99, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      // Illegal load keeps date, then legal load recovers
      step(0, 1, 31, 6, 3, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 15, 6, 3, 0);
      step(0, 1, 10, 13, 3, 0);
      step(0, 1, 0, 5, 3, 0);
      step(0, 1, 10, 5, 100, 0);
      step(0, 1, 15, 6, 3, 0);
      // February handling
      step(0, 1, 28, 2, 4, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 29, 2, 4, 0);
      step(0, 1, 28, 2, 5, 0);
      step(0, 0, 0, 0, 0, 1);
      // Load beats tick, then back-to-back ticks
      step(0, 1, 10, 1, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1);
      // Reset during RUN
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 99) < 2);
         ld = ($urandom_range(0, 99) < 12);
         t  = ($urandom_range(0, 99) < 70);
         d  = (ld && $urandom_range(0, 3) == 0) ? int'($urandom_range(27, 31))
                                                 : int'($urandom_range(0, 31));
         m  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                          : int'($urandom_range(1, 12));
         if ($urandom_range(0, 3) == 0) m = 12;
         y  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 127))
                                          : int'($urandom_range(0, 99));
         step(r, ld, d, m, y, t);
      end
      step(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
